// File: rtl/lora_pkg.sv
// Shared constants and types for the LoRa event framer.
// Frame layout: HDR, TYPE, STAT, SUM, TAIL with SUM = TYPE ^ STAT.
package lora_pkg;

    localparam logic [7:0] FRAME_HDR  = 8'hAA;
    localparam logic [7:0] FRAME_TAIL = 8'h55;
    localparam logic [7:0] TYPE_EVT   = 8'h01;
    localparam logic [7:0] TYPE_HB    = 8'h02;

    // Bit positions of the debounced inputs inside the status word
    localparam int STAT_KEY_LSB  = 0;
    localparam int STAT_CO       = 4;
    localparam int STAT_ZHENDONG = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TYP,
        ST_DAT,
        ST_SUM,
        ST_TAIL
    } state_t;

    function automatic logic [7:0] frame_sum(input logic [7:0] frm_type,
                                             input logic [7:0] frm_stat);
        return frm_type ^ frm_stat;
    endfunction

endpackage

// File: rtl/lora_debounce.sv
// One-bit synchroniser plus debouncer. The output only follows the
// synchronised input after DEBOUNCE_CYC consecutive differing samples.
module lora_debounce #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Count consecutive samples that disagree with the output; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync1 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            cnt   <= '0;
            level <= sync1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lora_evt_framer.sv
// Debounces keys/CO/vibration inputs and emits a 5-byte status frame on
// every debounced change over a valid/ready byte interface.
// Optional feature: define LORA_HEARTBEAT_EN to add periodic TYPE=02 frames.
module lora_evt_framer
    import lora_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
`ifdef LORA_HEARTBEAT_EN
    parameter int HEARTBEAT_MS = 1000,
`endif
    parameter int DEBOUNCE_MS  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_key_en,
    input  logic       co,
    input  logic       zhendong,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [5:0] status
);

    localparam int DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;

    logic [5:0] raw_vec;
    logic [5:0] status_q;
    logic       pending;
    logic       pending_d;
    state_t     state;
    state_t     state_d;
    logic [7:0] tx_data_d;
    logic       tx_valid_d;
    logic       busy_d;
    logic [7:0] frm_type;
    logic [7:0] frm_type_d;
    logic [7:0] frm_stat;
    logic [7:0] frm_stat_d;
    logic       start_evt;
    logic       accept;

    // Gather the raw inputs into status bit order
    always_comb begin
        raw_vec = '0;
        raw_vec[STAT_KEY_LSB +: 4] = in_key_en;
        raw_vec[STAT_CO]           = co;
        raw_vec[STAT_ZHENDONG]     = zhendong;
    end

    for (genvar i = 0; i < 6; i++) begin : g_deb
        lora_debounce #(.DEBOUNCE_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[i]),
            .level (status[i])
        );
    end

    assign accept = tx_valid && tx_ready;

`ifdef LORA_HEARTBEAT_EN
    localparam int HB_CYC = CLK_HZ / 1000 * HEARTBEAT_MS;
    localparam int HBW    = $clog2(HB_CYC + 1);

    logic [HBW-1:0] hb_cnt;
    logic           hb_tc;
    logic           hb_pending;
    logic           hb_pending_d;
    logic           start_hb;

    assign hb_tc = (hb_cnt == HBW'(HB_CYC - 1));

    // Heartbeat period counter: wraps at terminal count, restarted by event frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
        end else if (start_evt || hb_tc) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    // Heartbeat request: cleared by any frame start, set at terminal count unless an event frame starts
    always_comb begin
        hb_pending_d = hb_pending;
        if (start_evt || start_hb) begin
            hb_pending_d = 1'b0;
        end
        if (hb_tc && !start_evt) begin
            hb_pending_d = 1'b1;
        end
    end

    // Heartbeat request register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_pending <= 1'b0;
        end else begin
            hb_pending <= hb_pending_d;
        end
    end
`endif

    // Frame sequencer: next state, next byte and handshake outputs
    always_comb begin
        state_d    = state;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        busy_d     = busy;
        frm_type_d = frm_type;
        frm_stat_d = frm_stat;
        start_evt  = 1'b0;
`ifdef LORA_HEARTBEAT_EN
        start_hb   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    start_evt  = 1'b1;
                    frm_type_d = TYPE_EVT;
                    frm_stat_d = {2'b00, status};
                    tx_data_d  = FRAME_HDR;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_HDR;
                end
`ifdef LORA_HEARTBEAT_EN
                else if (hb_pending) begin
                    start_hb   = 1'b1;
                    frm_type_d = TYPE_HB;
                    frm_stat_d = {2'b00, status};
                    tx_data_d  = FRAME_HDR;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_HDR;
                end
`endif
            end
            ST_HDR: begin
                if (accept) begin
                    tx_data_d = frm_type;
                    state_d   = ST_TYP;
                end
            end
            ST_TYP: begin
                if (accept) begin
                    tx_data_d = frm_stat;
                    state_d   = ST_DAT;
                end
            end
            ST_DAT: begin
                if (accept) begin
                    tx_data_d = frame_sum(frm_type, frm_stat);
                    state_d   = ST_SUM;
                end
            end
            ST_SUM: begin
                if (accept) begin
                    tx_data_d = FRAME_TAIL;
                    state_d   = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (accept) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending event: a change seen in the same cycle a frame starts must survive the clear
    always_comb begin
        pending_d = pending;
        if (start_evt) begin
            pending_d = 1'b0;
        end
        if (status != status_q) begin
            pending_d = 1'b1;
        end
    end

    // State, frame snapshot and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            frm_type <= 8'h00;
            frm_stat <= 8'h00;
            status_q <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            busy     <= busy_d;
            frm_type <= frm_type_d;
            frm_stat <= frm_stat_d;
            status_q <= status;
            pending  <= pending_d;
        end
    end

endmodule

// File: tb/tb_lora_evt_framer.sv
// Directed self-checking bench for lora_evt_framer (10 kHz clock, 1 ms debounce = 10 cycles).
module tb_lora_evt_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_key_en;
    logic       co;
    logic       zhendong;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [5:0] status;

    int total = 0;
    int bad   = 0;

    lora_evt_framer #(
        .CLK_HZ       (10_000),
`ifdef LORA_HEARTBEAT_EN
        .HEARTBEAT_MS (20),
`endif
        .DEBOUNCE_MS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_key_en (in_key_en),
        .co        (co),
        .zhendong  (zhendong),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .status    (status)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n     = 1'b0;
        in_key_en = 4'b0000;
        co        = 1'b0;
        zhendong  = 1'b0;
        tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Collects n_bytes accepted bytes; reports timeout, stall instability, busy gaps and accept span
    task automatic capture_frame(input bit toggle, input int n_bytes, output logic [39:0] frame,
                                 output bit timed_out, output bit unstable, output bit busy_gap,
                                 output int span);
        int         n = 0;
        int         cyc = 0;
        int         first = 0;
        bit         stalled = 1'b0;
        bit         phase = 1'b1;
        logic [7:0] held = 8'h00;
        frame = '0; timed_out = 1'b0; unstable = 1'b0; busy_gap = 1'b0; span = 0;
        while (n < n_bytes && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stalled && (!tx_valid || tx_data !== held)) unstable = 1'b1;
            if (toggle) begin
                tx_ready = phase;
                phase    = !phase;
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && !busy) busy_gap = 1'b1;
            if (tx_valid && tx_ready) begin
                frame   = {frame[31:0], tx_data};
                if (n == 0) first = cyc;
                span    = cyc - first;
                n++;
                stalled = 1'b0;
            end else if (tx_valid) begin
                stalled = 1'b1;
                held    = tx_data;
            end else if (n > 0) begin
                unstable = 1'b1;
            end
        end
        timed_out = (n < n_bytes);
    endtask

    task automatic wait_quiet(input int cycles, output bit seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (status !== 6'h00) begin bad++; $display("[TB] FAIL reset_status got=%h want=00", status); end
    endtask

    task automatic test_debounce_reject;
        bit seen;
        co = 1'b1;
        repeat (5) @(negedge clk);
        co = 1'b0;
        wait_quiet(40, seen);
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL glitch_no_frame got=%b want=0", seen); end
        total++; if (status !== 6'h00) begin bad++; $display("[TB] FAIL glitch_status got=%h want=00", status); end
    endtask

    task automatic test_event_frame;
        logic [39:0] frame;
        bit          to, unst, gap;
        int          span;
        int          n = 0;
        int          lat = 0;
        do_reset();
        in_key_en = 4'b0010;
        while (status !== 6'h02 && n < 100) begin @(negedge clk); n++; end
        total++; if (status !== 6'h02) begin bad++; $display("[TB] FAIL key_status got=%h want=02", status); end
        while (!tx_valid && lat < 10) begin @(negedge clk); lat++; end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL event_latency got=%0d want=2", lat); end
        capture_frame(1'b0, 5, frame, to, unst, gap, span);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL key_frame_timeout got=%b want=0", to); end
        total++; if (frame !== 40'hAA01020355) begin bad++; $display("[TB] FAIL key_frame got=%h want=AA01020355", frame); end
        total++; if (span !== 4) begin bad++; $display("[TB] FAIL key_frame_span got=%0d want=4", span); end
        total++; if (gap !== 1'b0) begin bad++; $display("[TB] FAIL key_frame_busy got_gap=%b want=0", gap); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_after_tail got=%b want=0", busy); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_after_tail got=%b want=0", tx_valid); end
    endtask

    task automatic test_flow_control;
        logic [39:0] frame;
        bit          to, unst, gap;
        int          span;
        do_reset();
        zhendong = 1'b1;
        capture_frame(1'b1, 5, frame, to, unst, gap, span);
        total++; if (frame !== 40'hAA01202155) begin bad++; $display("[TB] FAIL toggle_frame got=%h want=AA01202155 to=%b", frame, to); end
        total++; if (unst !== 1'b0) begin bad++; $display("[TB] FAIL toggle_hold got=%b want=0", unst); end
        total++; if (gap !== 1'b0) begin bad++; $display("[TB] FAIL toggle_busy got_gap=%b want=0", gap); end
    endtask

    task automatic test_mid_frame_change;
        logic [39:0] f0, f1, f2, f3;
        bit          to, unst, gap, seen;
        int          span;
        do_reset();
        zhendong = 1'b1;
        capture_frame(1'b0, 5, f0, to, unst, gap, span);
        total++; if (f0 !== 40'hAA01202155) begin bad++; $display("[TB] FAIL mid_pre_frame got=%h want=AA01202155", f0); end
        zhendong = 1'b0;
        capture_frame(1'b0, 1, f1, to, unst, gap, span);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        co = 1'b1;
        repeat (5) @(negedge clk);
        in_key_en = 4'b0001;
        repeat (40) @(negedge clk);
        capture_frame(1'b0, 4, f2, to, unst, gap, span);
        total++; if ({f1[7:0], f2[31:0]} !== 40'hAA01000155) begin bad++; $display("[TB] FAIL mid_snapshot got=%h want=AA01000155", {f1[7:0], f2[31:0]}); end
        capture_frame(1'b0, 5, f3, to, unst, gap, span);
        total++; if (f3 !== 40'hAA01111055) begin bad++; $display("[TB] FAIL mid_follow got=%h want=AA01111055 to=%b", f3, to); end
        wait_quiet(60, seen);
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL mid_collapse extra_frame=%b want=0", seen); end
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] f;
        bit          to, unst, gap, seen;
        int          span;
        do_reset();
        in_key_en = 4'b0010;
        capture_frame(1'b0, 2, f, to, unst, gap, span);
        total++; if (f[15:0] !== 16'hAA01) begin bad++; $display("[TB] FAIL rst_prefix got=%h want=AA01", f[15:0]); end
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_data !== 8'h02) begin bad++; $display("[TB] FAIL rst_dat_byte got=%h want=02 valid=%b", tx_data, tx_valid); end
        rst_n     = 1'b0;
        in_key_en = 4'b0000;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid got=%b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        wait_quiet(60, seen);
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_resume got=%b want=0", seen); end
    endtask

`ifdef LORA_HEARTBEAT_EN
    task automatic test_heartbeat;
        logic [39:0] f0, f1, f2, f3, f4, f5;
        bit          to, unst, gap;
        int          span;
        int          idle = 0;
        do_reset();
        in_key_en = 4'b0100;
        capture_frame(1'b0, 5, f0, to, unst, gap, span);
        total++; if (f0 !== 40'hAA01040555) begin bad++; $display("[TB] FAIL hb_event got=%h want=AA01040555", f0); end
        capture_frame(1'b0, 5, f1, to, unst, gap, span);
        total++; if (f1 !== 40'hAA02040655) begin bad++; $display("[TB] FAIL hb_frame got=%h want=AA02040655 to=%b", f1, to); end
        capture_frame(1'b0, 1, f2, to, unst, gap, span);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        in_key_en = 4'b0101;
        repeat (250) @(negedge clk);
        capture_frame(1'b0, 4, f3, to, unst, gap, span);
        total++; if ({f2[7:0], f3[31:0]} !== 40'hAA02040655) begin bad++; $display("[TB] FAIL hb_snapshot got=%h want=AA02040655", {f2[7:0], f3[31:0]}); end
        capture_frame(1'b0, 5, f4, to, unst, gap, span);
        total++; if (f4 !== 40'hAA01050455) begin bad++; $display("[TB] FAIL hb_priority got=%h want=AA01050455", f4); end
        while (!tx_valid && idle < 400) begin @(negedge clk); idle++; end
        total++; if (idle <= 100) begin bad++; $display("[TB] FAIL hb_suppressed idle=%0d want>100", idle); end
        capture_frame(1'b0, 5, f5, to, unst, gap, span);
        total++; if (f5 !== 40'hAA02050755) begin bad++; $display("[TB] FAIL hb_next got=%h want=AA02050755 to=%b", f5, to); end
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_debounce_reject();
        test_event_frame();
        test_flow_control();
        test_mid_frame_change();
        test_reset_mid_frame();
`ifdef LORA_HEARTBEAT_EN
        test_heartbeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
